// File: rtl/cache_fill_fsm.sv
// Cache line fill controller: on a miss, fetches the 8-word (16-byte) line and then pulses the tag-array write.
// Latency: a fill starts on the miss edge; each word needs 4 unstalled FILL cycles; the tag pulse follows the 8th word by one cycle.
// Backpressure: memBusy freezes the latency counter and blocks word acceptance; fsm_busy stalls the pipeline for the whole fill plus the tag cycle.

// Single storage bit with asynchronous active-low clear.
module dff (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    // Capture on the rising edge; reset clears without waiting for the clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_o <= 1'b0;
        end else begin
            q_o <= d_i;
        end
    end
endmodule

// Full adder cell used to build every incrementer in the block.
module one_bit_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);
    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// W-bit register assembled from individual dff cells.
module dff_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    for (genvar i = 0; i < W; i++) begin : g_bit
        dff u_dff (
            .clk   (clk),
            .rst_n (rst_n),
            .d_i   (d_i[i]),
            .q_o   (q_o[i])
        );
    end
endmodule

// W-bit ripple-carry adder chained from one_bit_adder cells.
module ripple_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic [W:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < W; i++) begin : g_stage
        one_bit_adder u_fa (
            .a_i    (a_i[i]),
            .b_i    (b_i[i]),
            .cin_i  (carry[i]),
            .sum_o  (sum_o[i]),
            .cout_o (carry[i+1])
        );
    end

    assign cout_o = carry[W];
endmodule

module cache_fill_fsm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        miss_detected,
    input  logic [15:0] miss_address,
    input  logic        memory_data_valid,
    input  logic        memBusy,
    output logic        fsm_busy,
    output logic        write_data_array,
    output logic        write_tag_array,
    output logic [15:0] memory_address
);
    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    state_e      state_q;
    state_e      state_d;
    logic        state_q_raw;

    logic [1:0]  lat_q;
    logic [1:0]  lat_d;
    logic [1:0]  lat_inc;
    logic        lat_cout;

    logic [2:0]  word_q;
    logic [2:0]  word_d;
    logic [2:0]  word_inc;
    logic        word_wrap;

    logic [15:0] addr_q;
    logic [15:0] addr_d;
    logic [15:0] addr_inc;
    logic        addr_cout;

    logic        tag_q;
    logic        tag_d;
    logic        accept;

    // Carry-outs of the latency and address chains are intentionally dropped (both wrap).
    logic        unused_carries;
    assign unused_carries = &{1'b0, lat_cout, addr_cout};

    // State and datapath registers, all built from dff cells.
    dff_reg #(.W(1)) u_state_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (state_d),
        .q_o   (state_q_raw)
    );
    assign state_q = state_e'(state_q_raw);

    dff_reg #(.W(2)) u_lat_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (lat_d),
        .q_o   (lat_q)
    );

    dff_reg #(.W(3)) u_word_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (word_d),
        .q_o   (word_q)
    );

    dff_reg #(.W(16)) u_addr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (addr_d),
        .q_o   (addr_q)
    );

    dff_reg #(.W(1)) u_tag_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (tag_d),
        .q_o   (tag_q)
    );

    // Incrementers: latency +1, word +1 (its carry marks the 8th word), address +2.
    ripple_add #(.W(2)) u_lat_inc (
        .a_i    (lat_q),
        .b_i    (2'b00),
        .cin_i  (1'b1),
        .sum_o  (lat_inc),
        .cout_o (lat_cout)
    );

    ripple_add #(.W(3)) u_word_inc (
        .a_i    (word_q),
        .b_i    (3'b000),
        .cin_i  (1'b1),
        .sum_o  (word_inc),
        .cout_o (word_wrap)
    );

    ripple_add #(.W(16)) u_addr_inc (
        .a_i    (addr_q),
        .b_i    (16'h0002),
        .cin_i  (1'b0),
        .sum_o  (addr_inc),
        .cout_o (addr_cout)
    );

    // Next-state logic: load on miss in IDLE, count latency and accept words in FILL.
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        word_d  = word_q;
        addr_d  = addr_q;
        tag_d   = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d = FILL;
                    addr_d  = miss_address & 16'hFFF0;
                    lat_d   = 2'b00;
                    word_d  = 3'b000;
                end
            end
            FILL: begin
                // A word is only taken on the last latency slot; without valid the slot is lost.
                accept = (lat_q == 2'b11) && memory_data_valid && !memBusy;
                if (!memBusy) begin
                    lat_d = lat_inc;
                end
                if (accept) begin
                    addr_d = addr_inc;
                    word_d = word_inc;
                    if (word_wrap) begin
                        state_d = IDLE;
                        tag_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign write_data_array = (state_q == FILL);
    assign write_tag_array  = tag_q;
    assign fsm_busy         = write_data_array | write_tag_array;
    assign memory_address   = addr_q;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Testbench for cache_fill_fsm: constant vector table, directed line-fill sequences and random traffic.
// Latency: outputs sampled 1 time unit after each rising edge; inputs change at the same point.
// Backpressure: memBusy is exercised both in the table and randomly.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        memory_data_valid;
    logic        memBusy;
    logic        fsm_busy;
    logic        write_data_array;
    logic        write_tag_array;
    logic [15:0] memory_address;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memBusy           (memBusy),
        .fsm_busy          (fsm_busy),
        .write_data_array  (write_data_array),
        .write_tag_array   (write_tag_array),
        .memory_address    (memory_address)
    );

    // Reference model: a line is a base address plus a count of words fetched so far.
    bit          m_filling;
    int          m_slot;
    int          m_words;
    logic [15:0] m_base;
    logic [15:0] m_addr;
    bit          m_tag;

    task automatic model_reset();
        m_filling = 0;
        m_slot    = 0;
        m_words   = 0;
        m_base    = 16'h0000;
        m_addr    = 16'h0000;
        m_tag     = 0;
    endtask

    task automatic model_clock(input logic miss, input logic [15:0] ma, input logic v, input logic b);
        bit tag_next;
        bit take;
        tag_next = 0;
        if (!m_filling) begin
            if (miss) begin
                m_filling = 1;
                m_base    = ma & 16'hFFF0;
                m_addr    = m_base;
                m_slot    = 0;
                m_words   = 0;
            end
        end else begin
            take = (m_slot == 3) && v && !b;
            if (!b) m_slot = (m_slot + 1) % 4;
            if (take) begin
                m_words = m_words + 1;
                m_addr  = m_base + 16'(2 * m_words);
                if (m_words == 8) begin
                    m_filling = 0;
                    m_words   = 0;
                    tag_next  = 1;
                end
            end
        end
        m_tag = tag_next;
    endtask

    task automatic check(input string name, input logic [15:0] ea, input logic ewd, input logic ewt, input logic eb);
        vectors++;
        if (memory_address !== ea || write_data_array !== ewd || write_tag_array !== ewt || fsm_busy !== eb) begin
            miscompares++;
            $display("FAIL %s: got addr=%h wda=%b wta=%b busy=%b, expected addr=%h wda=%b wta=%b busy=%b",
                     name, memory_address, write_data_array, write_tag_array, fsm_busy, ea, ewd, ewt, eb);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_addr, m_filling, m_tag, m_filling | m_tag);
    endtask

    task automatic step(input logic miss, input logic [15:0] ma, input logic v, input logic b);
        miss_detected     = miss;
        miss_address      = ma;
        memory_data_valid = v;
        memBusy           = b;
        @(posedge clk);
        model_clock(miss, ma, v, b);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_n             = 1'b0;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memBusy           = 1'b0;
        #1;
        model_reset();
        check(name, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        miss;
        logic [15:0] ma;
        logic        v;
        logic        b;
        logic [15:0] ea;
        logic        ewd;
        logic        ewt;
        logic        eb;
    } vec_t;

    function automatic vec_t mk(input logic miss, input logic [15:0] ma, input logic v, input logic b,
                                input logic [15:0] ea, input logic ewd, input logic ewt, input logic eb);
        vec_t r;
        r.miss = miss; r.ma = ma; r.v = v; r.b = b;
        r.ea = ea; r.ewd = ewd; r.ewt = ewt; r.eb = eb;
        return r;
    endfunction

    vec_t tbl[22];

    initial begin
        logic [15:0] ea;
        // Table: reset idle, miss load, ignored second miss, lost slot, stall, stall at slot 3.
        tbl[0]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        tbl[1]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        tbl[2]  = mk(0, 16'h0000, 0, 0, 16'h0000, 0, 0, 0);
        tbl[3]  = mk(1, 16'h1233, 0, 0, 16'h1230, 1, 0, 1);
        tbl[4]  = mk(1, 16'hFFFF, 0, 0, 16'h1230, 1, 0, 1);
        tbl[5]  = mk(0, 16'hFFFF, 1, 0, 16'h1230, 1, 0, 1);
        tbl[6]  = mk(0, 16'h0000, 1, 0, 16'h1230, 1, 0, 1);
        tbl[7]  = mk(0, 16'h0000, 0, 0, 16'h1230, 1, 0, 1);
        tbl[8]  = mk(0, 16'h0000, 1, 0, 16'h1230, 1, 0, 1);
        tbl[9]  = mk(0, 16'h0000, 1, 0, 16'h1230, 1, 0, 1);
        tbl[10] = mk(0, 16'h0000, 0, 0, 16'h1230, 1, 0, 1);
        tbl[11] = mk(0, 16'h0000, 1, 0, 16'h1232, 1, 0, 1);
        for (int i = 12; i < 17; i++) tbl[i] = mk(0, 16'h0000, 1, 1, 16'h1232, 1, 0, 1);
        tbl[17] = mk(0, 16'h0000, 1, 0, 16'h1232, 1, 0, 1);
        tbl[18] = mk(0, 16'h0000, 1, 0, 16'h1232, 1, 0, 1);
        tbl[19] = mk(0, 16'h0000, 1, 0, 16'h1232, 1, 0, 1);
        tbl[20] = mk(0, 16'h0000, 1, 1, 16'h1232, 1, 0, 1);
        tbl[21] = mk(0, 16'h0000, 1, 0, 16'h1234, 1, 0, 1);

        rst_n             = 1'b1;
        miss_detected     = 1'b0;
        miss_address      = 16'h0000;
        memory_data_valid = 1'b0;
        memBusy           = 1'b0;
        #2;
        do_reset("reset_initial");

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].miss, tbl[i].ma, tbl[i].v, tbl[i].b);
            check($sformatf("tbl%0d", i), tbl[i].ea, tbl[i].ewd, tbl[i].ewt, tbl[i].eb);
        end

        // Full line with valid held high: one word every 4th cycle, then the tag pulse.
        do_reset("reset_line");
        step(1, 16'h1233, 0, 0);
        check("line_load", 16'h1230, 1, 0, 1);
        for (int k = 0; k < 32; k++) begin
            step(0, 16'hFFFF, 1, 0);
            ea = 16'h1230 + 16'(2 * ((k + 1) / 4));
            check($sformatf("line_cyc%0d", k), ea, (k < 31), (k == 31), 1'b1);
        end
        step(0, 16'h0000, 0, 0);
        check("line_after_tag", 16'h1240, 0, 0, 0);

        // New miss right after the tag pulse, at the top of the address space.
        step(1, 16'hFFF7, 0, 0);
        check("wrap_load", 16'hFFF0, 1, 0, 1);
        for (int k = 0; k < 32; k++) begin
            step(0, 16'h0000, 1, 0);
            check_model($sformatf("wrap_cyc%0d", k));
        end
        check("wrap_end", 16'h0000, 0, 1, 1);
        step(0, 16'h0000, 0, 0);
        check("wrap_idle", 16'h0000, 0, 0, 0);

        // Reset in the middle of a fill: immediate IDLE, no tag pulse afterwards.
        step(1, 16'hFFF7, 0, 0);
        for (int k = 0; k < 10; k++) step(0, 16'h0000, 1, 0);
        check("abort_before", 16'hFFF4, 1, 0, 1);
        do_reset("abort_reset");
        for (int k = 0; k < 3; k++) begin
            step(0, 16'h0000, 1, 0);
            check($sformatf("abort_idle%0d", k), 16'h0000, 0, 0, 0);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset($sformatf("rand_reset%0d", n));
            end else begin
                step(($urandom_range(0, 7) == 0), 16'($urandom), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) == 0));
                check_model($sformatf("rand%0d", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
CACHE_FILL_FSM -- requirements
Module: cache_fill_fsm

Interface
REQ-001 SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 miss_detected  input  1  high for one cycle when tag-match logic detects a cache miss.
REQ-005 miss_address  input  16  byte address that missed; sampled only with miss_detected.
REQ-006 memory_data_valid  input  1  high when valid data is returning on the memory bus.
REQ-007 memBusy  input  1  high when memory is busy; stalls the latency counter and word acceptance.
REQ-008 fsm_busy  output  1  high while a fill is in progress or the tag write is pending (pipeline stall).
REQ-009 write_data_array  output  1  cache data-array write enable.
REQ-010 write_tag_array  output  1  cache tag-array write enable, one-cycle pulse after the fill completes.
REQ-011 memory_address  output  16  registered byte address of the word being fetched.

Function
REQ-012 SHALL implement two states: IDLE and FILL (one state flop).
REQ-013 SHALL build every flop from dff cells (async active-low clear) and every incrementer from ripple chains of one_bit_adder cells.
REQ-014 IDLE->FILL SHALL occur on the clock edge where miss_detected=1; on that edge memory_address SHALL load miss_address & 16'hFFF0 and both counters SHALL clear to 0.
REQ-015 miss_detected SHALL be ignored while in FILL (no reload, no restart).
REQ-016 A 2-bit latency counter SHALL increment (wrapping 3->0) on each FILL cycle with memBusy=0; it SHALL hold when memBusy=1 or in IDLE.
REQ-017 A word SHALL be accepted on a FILL cycle where latency counter=3, memory_data_valid=1 and memBusy=0.
REQ-018 On an accepted word memory_address SHALL increment by 2 (16-bit, wrap-around, carry-out discarded) and a 3-bit word counter SHALL increment.
REQ-019 write_data_array SHALL equal 1 in every FILL cycle and 0 in IDLE.
REQ-020 FILL->IDLE SHALL occur on the edge that accepts the 8th word (word counter 7 overflowing to 0); a line is 8 words / 16 bytes.
REQ-021 write_tag_array SHALL be a registered signal: high for exactly the one cycle after the FILL->IDLE edge.
REQ-022 fsm_busy SHALL equal write_data_array OR write_tag_array.
REQ-023 If latency counter=3 with memory_data_valid=0, counter SHALL wrap to 0 and no word is accepted; the word waits for a later valid.
REQ-024 Outside FILL, memory_address SHALL hold its value unless a new miss loads it.
REQ-025 A miss in the cycle immediately after the tag pulse starts a new fill normally.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, latency counter=0, word counter=0, memory_address=16'h0000, write_tag_array=0; hence write_data_array=0, fsm_busy=0.
REQ-027 Reset asserted mid-fill SHALL abort the fill without a tag pulse; after release the block waits in IDLE for a new miss.

Verification
REQ-028 Reset then 3 idle cycles -> all outputs 0, memory_address=16'h0000.
REQ-029 miss_detected=1, miss_address=16'h1233 one cycle -> next cycle FILL, memory_address=16'h1230, write_data_array=1, fsm_busy=1; miss_address=16'hFFFF afterwards has no effect.
REQ-030 memBusy=0, memory_data_valid held 1 -> a word accepted every 4th cycle, memory_address 16'h1230,1232,...,123E; after the 8th word write_data_array=0 and write_tag_array=1 for one cycle, then fsm_busy=0.
REQ-031 memory_data_valid pulsed only on some cycles with counter≠3 -> no address change; valid at counter=3 -> address +2.
REQ-032 memBusy=1 for 5 cycles mid-fill -> latency counter and memory_address frozen, FILL held, fsm_busy=1.
REQ-033 Miss at 16'hFFF7 -> fill of 16'hFFF0..16'hFFFE; rst_n pulsed low mid-fill -> immediate IDLE, no tag pulse.
